// File: rtl/pbpix_fifo_pkg.sv
// Shared types and helpers for the pbpix stream FIFO family.
// Used by the FIFO top and by its pointer/flag controller.
package pbpix_fifo_pkg;

    typedef enum logic {
        FP_OFF = 1'b0,
        FP_ON  = 1'b1
    } fp_mode_e;

    function automatic fp_mode_e fp_mode(input int unsigned full_pass);
        return (full_pass != 0) ? FP_ON : FP_OFF;
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pbpix_fifo_ctrl.sv
// Pointer, occupancy and handshake control for a pbpix FIFO.
// Holds no storage, so SRAM-backed variants can reuse it.
module pbpix_fifo_ctrl
    import pbpix_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter fp_mode_e    MODE  = FP_OFF,
    parameter int unsigned AW    = 2,
    parameter int unsigned CW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          src_rdy,
    input  logic          dst_ack,
    output logic          src_ack,
    output logic          dst_rdy,
    output logic          push,
    output logic          pop,
    output logic [AW-1:0] wptr,
    output logic [AW-1:0] rptr,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam logic [AW-1:0] LAST       = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [CW-1:0] count_nxt;

    // In pass mode a full FIFO still accepts when the head leaves this cycle.
    always_comb begin
        src_ack = !full || ((MODE == FP_ON) && dst_ack);
        dst_rdy = !empty;
        push    = src_rdy && src_ack;
        pop     = dst_rdy && dst_ack;
    end

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 1'b1;
        end else if (pop && !push) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (push) begin
                wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
            end
            if (pop) begin
                rptr <= (rptr == LAST) ? '0 : rptr + 1'b1;
            end
            count <= count_nxt;
            full  <= (count_nxt == FULL_COUNT);
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/pbpix_fifo.sv
// rdy/ack FIFO for pbpix beats (data word + zero flag).
// Zero beats skip the data-array write and read back as 0.
module pbpix_fifo
    import pbpix_fifo_pkg::*;
#(
    parameter  int unsigned DW        = 16,
    parameter  int unsigned DEPTH     = 4,
    parameter  int unsigned FULL_PASS = 0,
    localparam int unsigned CW        = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          src_rdy,
    output logic          src_ack,
    input  logic          src_zero,
    input  logic [DW-1:0] src_data,
    output logic          dst_rdy,
    input  logic          dst_ack,
    output logic          dst_zero,
    output logic [DW-1:0] dst_data,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);

    localparam int unsigned AW = ptr_width(DEPTH);

    typedef struct packed {
        logic          zero;
        logic [DW-1:0] data;
    } beat_t;

    if (DEPTH < 2) begin : g_depth_check
        $error("pbpix_fifo: DEPTH must be at least 2");
    end

    logic          push;
    logic          pop;
    logic          data_we;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    beat_t         head;

    logic [DEPTH-1:0] zero_mem;
    logic [DW-1:0]    data_mem [DEPTH];

    pbpix_fifo_ctrl #(
        .DEPTH (DEPTH),
        .MODE  (fp_mode(FULL_PASS)),
        .AW    (AW),
        .CW    (CW)
    ) u_ctrl (
        .clk     (i_clk),
        .rst_n   (i_rstn),
        .src_rdy (src_rdy),
        .dst_ack (dst_ack),
        .src_ack (src_ack),
        .dst_rdy (dst_rdy),
        .push    (push),
        .pop     (pop),
        .wptr    (wptr),
        .rptr    (rptr),
        .count   (o_count),
        .full    (o_full),
        .empty   (o_empty)
    );

    assign data_we = push && !src_zero;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            zero_mem <= '0;
        end else if (push) begin
            zero_mem[wptr] <= src_zero;
        end
    end

    always_ff @(posedge i_clk) begin
        if (data_we) begin
            data_mem[wptr] <= src_data;
        end
    end

    // Combinational read of the current head: a same-slot pass-through write lands after it.
    always_comb begin
        head.zero = zero_mem[rptr] && dst_rdy;
        head.data = (dst_rdy && !head.zero) ? data_mem[rptr] : '0;
    end

    assign dst_zero = head.zero;
    assign dst_data = head.data;

`ifndef SYNTHESIS
    a_no_overflow : assert property (@(posedge i_clk) disable iff (!i_rstn)
        (push && o_full) |-> pop);
    a_no_underflow : assert property (@(posedge i_clk) disable iff (!i_rstn)
        pop |-> !o_empty);
    a_src_stable : assert property (@(posedge i_clk) disable iff (!i_rstn)
        (src_rdy && !src_ack) |=> (src_rdy && $stable(src_zero) && $stable(src_data)));
`endif

endmodule

// File: tb/tb_pbpix_fifo.sv
// Directed and scoreboard checks for pbpix_fifo in three configurations.
// Instance 0: DEPTH=4 no pass; 1: DEPTH=4 pass; 2: DEPTH=3 pass.
module tb_pbpix_fifo;

    localparam int unsigned DW = 16;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic          s_rdy  [3];
    logic          s_zero [3];
    logic [DW-1:0] s_data [3];
    logic          d_ack  [3];
    logic          s_ack  [3];
    logic          d_rdy  [3];
    logic          d_zero [3];
    logic [DW-1:0] d_data [3];
    logic          full   [3];
    logic          empty  [3];
    logic [2:0]    cnt0;
    logic [2:0]    cnt1;
    logic [1:0]    cnt2;

    int n_tests = 0;
    int n_fail  = 0;

    pbpix_fifo #(.DW(DW), .DEPTH(4), .FULL_PASS(0)) dut0 (
        .i_clk(clk), .i_rstn(rstn),
        .src_rdy(s_rdy[0]), .src_ack(s_ack[0]), .src_zero(s_zero[0]), .src_data(s_data[0]),
        .dst_rdy(d_rdy[0]), .dst_ack(d_ack[0]), .dst_zero(d_zero[0]), .dst_data(d_data[0]),
        .o_count(cnt0), .o_full(full[0]), .o_empty(empty[0])
    );

    pbpix_fifo #(.DW(DW), .DEPTH(4), .FULL_PASS(1)) dut1 (
        .i_clk(clk), .i_rstn(rstn),
        .src_rdy(s_rdy[1]), .src_ack(s_ack[1]), .src_zero(s_zero[1]), .src_data(s_data[1]),
        .dst_rdy(d_rdy[1]), .dst_ack(d_ack[1]), .dst_zero(d_zero[1]), .dst_data(d_data[1]),
        .o_count(cnt1), .o_full(full[1]), .o_empty(empty[1])
    );

    pbpix_fifo #(.DW(DW), .DEPTH(3), .FULL_PASS(1)) dut2 (
        .i_clk(clk), .i_rstn(rstn),
        .src_rdy(s_rdy[2]), .src_ack(s_ack[2]), .src_zero(s_zero[2]), .src_data(s_data[2]),
        .dst_rdy(d_rdy[2]), .dst_ack(d_ack[2]), .dst_zero(d_zero[2]), .dst_data(d_data[2]),
        .o_count(cnt2), .o_full(full[2]), .o_empty(empty[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input int i, input logic z, input logic [DW-1:0] v);
        s_rdy[i]  = 1'b1;
        s_zero[i] = z;
        s_data[i] = v;
        #1;
        check("push_ack", 32'(s_ack[i]), 32'd1);
        tick();
        s_rdy[i]  = 1'b0;
        s_zero[i] = 1'b0;
    endtask

    task automatic pop_beat(input int i, input logic z, input logic [DW-1:0] v);
        d_ack[i] = 1'b1;
        #1;
        check("pop_rdy", 32'(d_rdy[i]), 32'd1);
        check("pop_zero", 32'(d_zero[i]), 32'(z));
        check("pop_data", 32'(d_data[i]), 32'(v));
        tick();
        d_ack[i] = 1'b0;
    endtask

    typedef struct packed {
        logic          zero;
        logic [DW-1:0] data;
    } beat_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t sb[$];
        beat_t front;
        logic  exp_ack;
        logic  acked;
        int    popped;
        int    cycles;

        for (int i = 0; i < 3; i++) begin
            s_rdy[i]  = 1'b0;
            s_zero[i] = 1'b0;
            s_data[i] = '0;
            d_ack[i]  = 1'b0;
        end

        // Reset state
        #23;
        rstn = 1'b1;
        #1;
        check("rst_dst_rdy", 32'(d_rdy[0]), 32'd0);
        check("rst_src_ack", 32'(s_ack[0]), 32'd1);
        check("rst_count", 32'(cnt0), 32'd0);
        check("rst_empty", 32'(empty[0]), 32'd1);
        check("rst_full", 32'(full[0]), 32'd0);
        check("rst_dst_data", 32'(d_data[0]), 32'd0);
        check("rst_dst_zero", 32'(d_zero[0]), 32'd0);
        check("rst_count_d3", 32'(cnt2), 32'd0);
        tick();

        // Fill to full, then drain in order
        push_beat(0, 1'b0, 16'h0011);
        push_beat(0, 1'b0, 16'h0022);
        push_beat(0, 1'b0, 16'h0033);
        push_beat(0, 1'b0, 16'h0044);
        check("full_src_ack", 32'(s_ack[0]), 32'd0);
        check("full_flag", 32'(full[0]), 32'd1);
        check("full_count", 32'(cnt0), 32'd4);
        check("full_dst_rdy", 32'(d_rdy[0]), 32'd1);
        pop_beat(0, 1'b0, 16'h0011);
        pop_beat(0, 1'b0, 16'h0022);
        pop_beat(0, 1'b0, 16'h0033);
        pop_beat(0, 1'b0, 16'h0044);
        #1;
        check("drain_empty", 32'(empty[0]), 32'd1);
        check("drain_count", 32'(cnt0), 32'd0);
        check("drain_dst_rdy", 32'(d_rdy[0]), 32'd0);
        check("drain_dst_data", 32'(d_data[0]), 32'd0);

        // Zero beat: slot 0 still holds 0x0011 and must not be overwritten
        s_rdy[0]  = 1'b1;
        s_zero[0] = 1'b1;
        s_data[0] = 16'hBEEF;
        #1;
        check("zero_we", 32'(dut0.data_we), 32'd0);
        check("latency_no_bypass", 32'(d_rdy[0]), 32'd0);
        tick();
        s_rdy[0]  = 1'b0;
        s_zero[0] = 1'b0;
        #1;
        check("zero_dst_rdy", 32'(d_rdy[0]), 32'd1);
        check("zero_dst_zero", 32'(d_zero[0]), 32'd1);
        check("zero_dst_data", 32'(d_data[0]), 32'd0);
        check("zero_mem_kept", 32'(dut0.data_mem[0]), 32'h0011);
        push_beat(0, 1'b0, 16'h1234);
        pop_beat(0, 1'b1, 16'h0000);
        pop_beat(0, 1'b0, 16'h1234);

        // Full-pass mode: simultaneous push and pop while full
        push_beat(1, 1'b0, 16'h00A0);
        push_beat(1, 1'b0, 16'h00A1);
        push_beat(1, 1'b0, 16'h00A2);
        push_beat(1, 1'b0, 16'h00A3);
        check("fp1_full", 32'(full[1]), 32'd1);
        for (int k = 0; k < 3; k++) begin
            s_rdy[1]  = 1'b1;
            s_data[1] = 16'(16'h00B0 + k);
            d_ack[1]  = 1'b1;
            #1;
            check("fp1_src_ack", 32'(s_ack[1]), 32'd1);
            check("fp1_head", 32'(d_data[1]), 32'(16'h00A0 + k));
            tick();
        end
        s_rdy[1] = 1'b0;
        d_ack[1] = 1'b0;
        #1;
        check("fp1_count", 32'(cnt1), 32'd4);
        check("fp1_still_full", 32'(full[1]), 32'd1);
        pop_beat(1, 1'b0, 16'h00A3);
        pop_beat(1, 1'b0, 16'h00B0);
        pop_beat(1, 1'b0, 16'h00B1);
        pop_beat(1, 1'b0, 16'h00B2);

        // No-pass mode, same stimulus: first cycle pops only
        push_beat(0, 1'b0, 16'h00C0);
        push_beat(0, 1'b0, 16'h00C1);
        push_beat(0, 1'b0, 16'h00C2);
        push_beat(0, 1'b0, 16'h00C3);
        s_rdy[0]  = 1'b1;
        s_data[0] = 16'h00D0;
        d_ack[0]  = 1'b1;
        #1;
        check("fp0_blocked", 32'(s_ack[0]), 32'd0);
        check("fp0_head0", 32'(d_data[0]), 32'h00C0);
        tick();
        #1;
        check("fp0_ack_b", 32'(s_ack[0]), 32'd1);
        check("fp0_head1", 32'(d_data[0]), 32'h00C1);
        check("fp0_count_b", 32'(cnt0), 32'd3);
        tick();
        s_data[0] = 16'h00D1;
        #1;
        check("fp0_ack_c", 32'(s_ack[0]), 32'd1);
        check("fp0_head2", 32'(d_data[0]), 32'h00C2);
        tick();
        s_rdy[0] = 1'b0;
        d_ack[0] = 1'b0;
        #1;
        check("fp0_count", 32'(cnt0), 32'd3);
        pop_beat(0, 1'b0, 16'h00C3);
        pop_beat(0, 1'b0, 16'h00D0);
        pop_beat(0, 1'b0, 16'h00D1);

        // Random traffic on DEPTH=3 against a queue model
        popped = 0;
        cycles = 0;
        while (popped < 2000 && cycles < 40000) begin
            if (!s_rdy[2] && ($urandom_range(3) != 0)) begin
                s_rdy[2]  = 1'b1;
                s_zero[2] = ($urandom_range(3) == 0);
                s_data[2] = 16'($urandom);
            end
            d_ack[2] = ($urandom_range(3) != 0);
            #1;
            exp_ack = (sb.size() < 3) || d_ack[2];
            check("rnd_src_ack", 32'(s_ack[2]), 32'(exp_ack));
            check("rnd_count", 32'(cnt2), 32'(sb.size()));
            check("rnd_dst_rdy", 32'(d_rdy[2]), 32'(sb.size() != 0));
            if (sb.size() != 0 && d_ack[2]) begin
                front = sb.pop_front();
                check("rnd_zero", 32'(d_zero[2]), 32'(front.zero));
                check("rnd_data", 32'(d_data[2]), 32'(front.data));
                popped++;
            end
            acked = s_rdy[2] && exp_ack;
            if (acked) begin
                sb.push_back({s_zero[2], s_zero[2] ? 16'h0000 : s_data[2]});
            end
            tick();
            cycles++;
            if (acked) begin
                s_rdy[2] = 1'b0;
            end
        end
        check("rnd_completed", 32'(popped >= 2000), 32'd1);
        if (s_rdy[2]) begin
            d_ack[2] = 1'b1;
            tick();
        end
        s_rdy[2] = 1'b0;
        d_ack[2] = 1'b0;

        // Asynchronous reset mid-cycle with two beats in flight
        push_beat(0, 1'b0, 16'h0101);
        push_beat(0, 1'b0, 16'h0202);
        check("pre_rst_count", 32'(cnt0), 32'd2);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_dst_rdy", 32'(d_rdy[0]), 32'd0);
        check("arst_count", 32'(cnt0), 32'd0);
        check("arst_empty", 32'(empty[0]), 32'd1);
        check("arst_dst_data", 32'(d_data[0]), 32'd0);
        check("arst_zero_mem", 32'(dut2.zero_mem), 32'd0);
        tick();
        #2;
        rstn = 1'b1;
        tick();
        push_beat(0, 1'b0, 16'h0777);
        pop_beat(0, 1'b0, 16'h0777);
        #1;
        check("post_rst_empty", 32'(empty[0]), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
